avalon_arbiter2: RTL and testbench

- Two-master to one-slave Avalon-MM arbiter with round-robin priority.
- Lets the SPI bridge master (M0) and the JTAG master (M1) share a single slave port, for example the SDRAM controller inside vidor_sys.
- Holds the grant for a whole write burst, and for a read until every readdatavalid beat has returned.
- Routes read data back to the master that owns the grant.

---
 rtl/avalon_arb_pkg.sv | 24 ++
 rtl/rr_pick2.sv | 26 ++
 rtl/avalon_arbiter2.sv | 199 +++++++++++++++++++
 tb/tb_avalon_arbiter2.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_arb_pkg.sv
// avalon_arb_pkg
// Shared definitions for the two-master Avalon-MM arbiter.
// Contents:
//   ADDR_W_DEF, DATA_W_DEF, BURST_W_DEF : default bus widths
//   arbState_t                          : arbiter FSM states
//   GRANT_NONE, GRANT_M0, GRANT_M1      : one-hot grant encodings
package avalon_arb_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int BURST_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    WBURST = 2'd2,
    RDATA  = 2'd3
  } arbState_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2
// Two-input round-robin picker, purely combinational.
// Ports:
//   i_req [1:0] : request vector, bit 0 = M0, bit 1 = M1
//   i_pri       : 0 = M0 holds priority, 1 = M1 holds priority
//   o_gnt [1:0] : one-hot winner, 00 when nobody requests
module rr_pick2
  import avalon_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_pri,
  output logic [1:0] o_gnt
);

  // With a single requester it simply wins; only a tie consults the
  // priority pointer. A lone request vector is already one-hot.
  always_comb begin
    o_gnt = GRANT_NONE;
    if (i_req == 2'b11) begin
      o_gnt = i_pri ? GRANT_M1 : GRANT_M0;
    end else begin
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/avalon_arbiter2.sv
// avalon_arbiter2
// Round-robin arbiter letting two Avalon-MM masters (M0 = SPI bridge,
// M1 = JTAG) share one slave. The grant is held for a whole write burst,
// and for a read until every readdatavalid beat has come back.
// Ports:
//   iCLK, iRESET                 : clock, async active-high reset
//   iMx_* / oMx_*  (x = 0,1)     : master-side Avalon-MM ports
//   oS_* / iS_*                  : slave-side Avalon-MM ports
//   oGRANT                       : one-hot current owner, 00 when idle
//   oERR                         : sticky, readdatavalid seen outside a read
module avalon_arbiter2
  import avalon_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic [ADDR_W-1:0]  iM0_ADDRESS,
  input  logic               iM0_READ,
  input  logic               iM0_WRITE,
  input  logic [DATA_W-1:0]  iM0_WRITE_DATA,
  input  logic [BURST_W-1:0] iM0_BURST_COUNT,
  output logic               oM0_WAIT_REQUEST,
  output logic [DATA_W-1:0]  oM0_READ_DATA,
  output logic               oM0_READ_DATAVALID,
  input  logic [ADDR_W-1:0]  iM1_ADDRESS,
  input  logic               iM1_READ,
  input  logic               iM1_WRITE,
  input  logic [DATA_W-1:0]  iM1_WRITE_DATA,
  input  logic [BURST_W-1:0] iM1_BURST_COUNT,
  output logic               oM1_WAIT_REQUEST,
  output logic [DATA_W-1:0]  oM1_READ_DATA,
  output logic               oM1_READ_DATAVALID,
  output logic [ADDR_W-1:0]  oS_ADDRESS,
  output logic               oS_READ,
  output logic               oS_WRITE,
  output logic [DATA_W-1:0]  oS_WRITE_DATA,
  output logic [BURST_W-1:0] oS_BURST_COUNT,
  input  logic               iS_WAIT_REQUEST,
  input  logic [DATA_W-1:0]  iS_READ_DATA,
  input  logic               iS_READ_DATAVALID,
  output logic [1:0]         oGRANT,
  output logic               oERR
);

  arbState_t          r_state, w_nextState;
  logic [1:0]         r_grant, w_nextGrant;
  logic               r_pri, w_nextPri;
  logic [BURST_W-1:0] r_beatsLeft, w_nextBeatsLeft;
  logic               r_err;

  logic [1:0]         w_req, w_pick;
  logic               w_release, w_grantedWait;
  logic               w_selRead, w_selWrite;
  logic [ADDR_W-1:0]  w_selAddr;
  logic [DATA_W-1:0]  w_selData;
  logic [BURST_W-1:0] w_selBc, w_bcEff;

  assign w_req = {iM1_READ | iM1_WRITE, iM0_READ | iM0_WRITE};

  rr_pick2 u_pick (
    .i_req (w_req),
    .i_pri (r_pri),
    .o_gnt (w_pick)
  );

  // Command fields of whichever master owns the grant; all zero when idle.
  always_comb begin
    w_selRead  = 1'b0;
    w_selWrite = 1'b0;
    w_selAddr  = '0;
    w_selData  = '0;
    w_selBc    = '0;
    if (r_grant == GRANT_M0) begin
      w_selRead  = iM0_READ;
      w_selWrite = iM0_WRITE;
      w_selAddr  = iM0_ADDRESS;
      w_selData  = iM0_WRITE_DATA;
      w_selBc    = iM0_BURST_COUNT;
    end else if (r_grant == GRANT_M1) begin
      w_selRead  = iM1_READ;
      w_selWrite = iM1_WRITE;
      w_selAddr  = iM1_ADDRESS;
      w_selData  = iM1_WRITE_DATA;
      w_selBc    = iM1_BURST_COUNT;
    end
  end

  // A burstcount of zero is treated as a single beat.
  assign w_bcEff = (w_selBc == '0) ? BURST_W'(1) : w_selBc;

  // Next-state and slave command logic. Release is flagged inside the case
  // and applied once afterwards so every exit path hands priority over the
  // same way. A write wins over a read if a master raises both.
  always_comb begin
    w_nextState     = r_state;
    w_nextGrant     = r_grant;
    w_nextPri       = r_pri;
    w_nextBeatsLeft = r_beatsLeft;
    w_release       = 1'b0;
    w_grantedWait   = 1'b1;
    oS_READ         = 1'b0;
    oS_WRITE        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_nextGrant = w_pick;
          w_nextState = CMD;
        end
      end
      CMD: begin
        oS_READ       = w_selRead & ~w_selWrite;
        oS_WRITE      = w_selWrite;
        w_grantedWait = iS_WAIT_REQUEST;
        if (!w_selRead && !w_selWrite) begin
          w_nextState = IDLE;
          w_nextGrant = GRANT_NONE;
        end else if (!iS_WAIT_REQUEST) begin
          if (w_selWrite) begin
            w_nextBeatsLeft = w_bcEff - BURST_W'(1);
            if (w_bcEff == BURST_W'(1)) begin
              w_release = 1'b1;
            end else begin
              w_nextState = WBURST;
            end
          end else begin
            w_nextBeatsLeft = w_bcEff;
            w_nextState     = RDATA;
          end
        end
      end
      WBURST: begin
        oS_WRITE      = w_selWrite;
        w_grantedWait = iS_WAIT_REQUEST;
        if (w_selWrite && !iS_WAIT_REQUEST && r_beatsLeft != '0) begin
          w_nextBeatsLeft = r_beatsLeft - BURST_W'(1);
          if (r_beatsLeft == BURST_W'(1)) begin
            w_release = 1'b1;
          end
        end
      end
      RDATA: begin
        if (iS_READ_DATAVALID && r_beatsLeft != '0) begin
          w_nextBeatsLeft = r_beatsLeft - BURST_W'(1);
          if (r_beatsLeft == BURST_W'(1)) begin
            w_release = 1'b1;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextGrant = GRANT_NONE;
      end
    endcase
    if (w_release) begin
      w_nextState = IDLE;
      w_nextGrant = GRANT_NONE;
      w_nextPri   = r_grant[0];
    end
  end

  // State registers. The error flag latches any readdatavalid that arrives
  // while no read is outstanding and only clears on reset.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_state     <= IDLE;
      r_grant     <= GRANT_NONE;
      r_pri       <= 1'b0;
      r_beatsLeft <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_grant     <= w_nextGrant;
      r_pri       <= w_nextPri;
      r_beatsLeft <= w_nextBeatsLeft;
      if (iS_READ_DATAVALID && r_state != RDATA) begin
        r_err <= 1'b1;
      end
    end
  end

  assign oS_ADDRESS     = w_selAddr;
  assign oS_WRITE_DATA  = w_selData;
  assign oS_BURST_COUNT = w_selBc;

  assign oM0_WAIT_REQUEST = r_grant[0] ? w_grantedWait : 1'b1;
  assign oM1_WAIT_REQUEST = r_grant[1] ? w_grantedWait : 1'b1;

  assign oM0_READ_DATA      = iS_READ_DATA;
  assign oM1_READ_DATA      = iS_READ_DATA;
  assign oM0_READ_DATAVALID = (r_state == RDATA) & r_grant[0] & iS_READ_DATAVALID;
  assign oM1_READ_DATAVALID = (r_state == RDATA) & r_grant[1] & iS_READ_DATAVALID;

  assign oGRANT = r_grant;
  assign oERR   = r_err;

endmodule

// File: tb/tb_avalon_arbiter2.sv
// tb_avalon_arbiter2
// Self-checking bench for avalon_arbiter2. Slave write acceptances and
// master read beats are matched against scoreboard queues filled when the
// corresponding stimulus is driven.
module tb_avalon_arbiter2;

  logic        iCLK, iRESET;
  logic [31:0] iM0_ADDRESS, iM1_ADDRESS;
  logic        iM0_READ, iM1_READ, iM0_WRITE, iM1_WRITE;
  logic [31:0] iM0_WRITE_DATA, iM1_WRITE_DATA;
  logic [4:0]  iM0_BURST_COUNT, iM1_BURST_COUNT;
  logic        oM0_WAIT_REQUEST, oM1_WAIT_REQUEST;
  logic [31:0] oM0_READ_DATA, oM1_READ_DATA;
  logic        oM0_READ_DATAVALID, oM1_READ_DATAVALID;
  logic [31:0] oS_ADDRESS, oS_WRITE_DATA;
  logic        oS_READ, oS_WRITE;
  logic [4:0]  oS_BURST_COUNT;
  logic        iS_WAIT_REQUEST;
  logic [31:0] iS_READ_DATA;
  logic        iS_READ_DATAVALID;
  logic [1:0]  oGRANT;
  logic        oERR;

  int checkCount = 0;
  int errorCount = 0;
  int writesSeen = 0;
  bit m1WaitLowSeen = 0;
  bit m1ValidSeen = 0;

  logic [63:0] expWriteQ[$];
  logic [63:0] expReadQ[$];

  avalon_arbiter2 dut (
    .iCLK               (iCLK),
    .iRESET             (iRESET),
    .iM0_ADDRESS        (iM0_ADDRESS),
    .iM0_READ           (iM0_READ),
    .iM0_WRITE          (iM0_WRITE),
    .iM0_WRITE_DATA     (iM0_WRITE_DATA),
    .iM0_BURST_COUNT    (iM0_BURST_COUNT),
    .oM0_WAIT_REQUEST   (oM0_WAIT_REQUEST),
    .oM0_READ_DATA      (oM0_READ_DATA),
    .oM0_READ_DATAVALID (oM0_READ_DATAVALID),
    .iM1_ADDRESS        (iM1_ADDRESS),
    .iM1_READ           (iM1_READ),
    .iM1_WRITE          (iM1_WRITE),
    .iM1_WRITE_DATA     (iM1_WRITE_DATA),
    .iM1_BURST_COUNT    (iM1_BURST_COUNT),
    .oM1_WAIT_REQUEST   (oM1_WAIT_REQUEST),
    .oM1_READ_DATA      (oM1_READ_DATA),
    .oM1_READ_DATAVALID (oM1_READ_DATAVALID),
    .oS_ADDRESS         (oS_ADDRESS),
    .oS_READ            (oS_READ),
    .oS_WRITE           (oS_WRITE),
    .oS_WRITE_DATA      (oS_WRITE_DATA),
    .oS_BURST_COUNT     (oS_BURST_COUNT),
    .iS_WAIT_REQUEST    (iS_WAIT_REQUEST),
    .iS_READ_DATA       (iS_READ_DATA),
    .iS_READ_DATAVALID  (iS_READ_DATAVALID),
    .oGRANT             (oGRANT),
    .oERR               (oERR)
  );

  // Free-running 10-unit clock.
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Hard stop in case something stalls forever.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] readEntry(input int m, input logic [31:0] data);
    return {30'd0, (m == 1), (m == 0), data};
  endfunction

  task automatic waitClk(input int n = 1);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic applyStimulus(input int m, input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [4:0] bc);
    if (m == 0) begin
      iM0_READ = rd; iM0_WRITE = wr; iM0_ADDRESS = addr; iM0_WRITE_DATA = data; iM0_BURST_COUNT = bc;
    end else begin
      iM1_READ = rd; iM1_WRITE = wr; iM1_ADDRESS = addr; iM1_WRITE_DATA = data; iM1_BURST_COUNT = bc;
    end
  endtask

  task automatic doReset();
    iRESET = 1'b1;
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0);
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 5'd0);
    iS_WAIT_REQUEST = 1'b0; iS_READ_DATA = 32'h0; iS_READ_DATAVALID = 1'b0;
    waitClk(2);
    iRESET = 1'b0;
    waitClk(1);
  endtask

  // Packs {grant, err, wait0, wait1, sread, swrite, dv0, dv1}; reset value 0_0_0_11_0000.
  task automatic checkResetOutputs(input string tag);
    checkOutput(tag, 64'({oGRANT, oERR, oM0_WAIT_REQUEST, oM1_WAIT_REQUEST, oS_READ, oS_WRITE,
                          oM0_READ_DATAVALID, oM1_READ_DATAVALID}), 64'(9'b00_0_11_0000));
  endtask

  // Slave-side and master-side monitor on the falling edge: every accepted
  // slave write and every read beat handed to a master must match the head
  // of its scoreboard queue.
  always @(negedge iCLK) begin
    if (!iRESET) begin
      if (!oM1_WAIT_REQUEST) m1WaitLowSeen = 1'b1;
      if (oM1_READ_DATAVALID) m1ValidSeen = 1'b1;
      if (oS_WRITE && !iS_WAIT_REQUEST) begin
        writesSeen++;
        checkOutput("wr_expected_pending", 64'(expWriteQ.size() != 0), 64'd1);
        if (expWriteQ.size() != 0) checkOutput("wr_beat", {oS_ADDRESS, oS_WRITE_DATA}, expWriteQ.pop_front());
      end
      if (oM0_READ_DATAVALID || oM1_READ_DATAVALID) begin
        checkOutput("rd_expected_pending", 64'(expReadQ.size() != 0), 64'd1);
        if (expReadQ.size() != 0)
          checkOutput("rd_beat", {30'd0, oM1_READ_DATAVALID, oM0_READ_DATAVALID, oM0_READ_DATA},
                      expReadQ.pop_front());
      end
    end
  end

  logic [1:0] grantSeq [8];
  int beat, stall;
  logic acc;

  // Directed scenarios: reset, single write, contention, stalled write
  // burst, gapped read burst, spurious readdatavalid and mid-read reset.
  initial begin
    grantSeq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    doReset();
    checkResetOutputs("reset_outputs");

    // Single write from M0.
    m1WaitLowSeen = 1'b0; writesSeen = 0;
    applyStimulus(0, 0, 1, 32'h0000_1000, 32'hA5A5_0001, 5'd1);
    expWriteQ.push_back({32'h0000_1000, 32'hA5A5_0001});
    #1;
    checkOutput("single_grant_before_edge", 64'(oGRANT), 64'(2'b00));
    waitClk();
    checkOutput("single_grant", 64'(oGRANT), 64'(2'b01));
    checkOutput("single_m0_wait", 64'(oM0_WAIT_REQUEST), 64'd0);
    waitClk();
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0);
    checkOutput("single_release", 64'(oGRANT), 64'(2'b00));
    waitClk(2);
    checkOutput("single_write_count", 64'(writesSeen), 64'd1);
    checkOutput("single_m1_never_unstalled", 64'(m1WaitLowSeen), 64'd0);

    // Both masters hammer single writes; grants must alternate.
    doReset();
    writesSeen = 0;
    applyStimulus(0, 0, 1, 32'h0000_2000, 32'h0000_00A0, 5'd1);
    applyStimulus(1, 0, 1, 32'h0000_3000, 32'h0000_00B0, 5'd1);
    for (int i = 0; i < 2; i++) begin
      expWriteQ.push_back({32'h0000_2000, 32'h0000_00A0});
      expWriteQ.push_back({32'h0000_3000, 32'h0000_00B0});
    end
    for (int i = 0; i < 8; i++) begin
      waitClk();
      checkOutput($sformatf("contention_grant%0d", i), 64'(oGRANT), 64'(grantSeq[i]));
    end
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0);
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 5'd0);
    waitClk(2);
    checkOutput("contention_write_count", 64'(writesSeen), 64'd4);

    // M1 four-beat write burst, slave stalls on beat 2 for 3 cycles; M0 waits.
    doReset();
    writesSeen = 0; beat = 0; stall = 0;
    applyStimulus(1, 0, 1, 32'h0000_4000, 32'hC000_0000, 5'd4);
    for (int k = 0; k < 4; k++) expWriteQ.push_back({32'h0000_4000, 32'hC000_0000 + 32'(k)});
    waitClk();
    checkOutput("burst_grant", 64'(oGRANT), 64'(2'b10));
    applyStimulus(0, 0, 1, 32'h0000_5000, 32'hD000_0000, 5'd1);
    expWriteQ.push_back({32'h0000_5000, 32'hD000_0000});
    for (int cyc = 0; cyc < 30 && beat < 4; cyc++) begin
      iS_WAIT_REQUEST = (beat == 1 && stall < 3);
      if (iS_WAIT_REQUEST) stall++;
      iM1_WRITE_DATA = 32'hC000_0000 + 32'(beat);
      #1;
      checkOutput("burst_m0_held", 64'(oM0_WAIT_REQUEST), 64'd1);
      acc = !oM1_WAIT_REQUEST;
      waitClk();
      if (acc) beat++;
    end
    iS_WAIT_REQUEST = 1'b0;
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 5'd0);
    checkOutput("burst_beats_accepted", 64'(beat), 64'd4);
    checkOutput("burst_release", 64'(oGRANT), 64'(2'b00));
    waitClk();
    checkOutput("burst_m0_after_release", 64'(oGRANT), 64'(2'b01));
    waitClk();
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0);
    waitClk(2);
    checkOutput("burst_write_count", 64'(writesSeen), 64'd5);
    checkOutput("burst_queue_drained", 64'(expWriteQ.size()), 64'd0);

    // M0 eight-beat read burst with gaps between beats.
    doReset();
    m1ValidSeen = 1'b0;
    applyStimulus(0, 1, 0, 32'h0000_6000, 32'h0, 5'd8);
    waitClk();
    checkOutput("read_grant", 64'(oGRANT), 64'(2'b01));
    checkOutput("read_cmd", 64'({oS_READ, oS_WRITE, oS_BURST_COUNT}), 64'({1'b1, 1'b0, 5'd8}));
    waitClk();
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0);
    #1;
    checkOutput("rdata_outputs", 64'({oS_READ, oS_WRITE, oM0_WAIT_REQUEST}), 64'(3'b001));
    for (int k = 0; k < 8; k++) begin
      if (k % 3 == 1) waitClk();
      iS_READ_DATAVALID = 1'b1;
      iS_READ_DATA = 32'hBEEF_0000 + 32'(k);
      expReadQ.push_back(readEntry(0, iS_READ_DATA));
      waitClk();
      iS_READ_DATAVALID = 1'b0;
    end
    checkOutput("read_release", 64'(oGRANT), 64'(2'b00));
    waitClk();
    checkOutput("read_queue_drained", 64'(expReadQ.size()), 64'd0);
    checkOutput("read_m1_never_valid", 64'(m1ValidSeen), 64'd0);
    checkOutput("read_no_err", 64'(oERR), 64'd0);

    // Spurious readdatavalid while idle sets the sticky error.
    iS_READ_DATAVALID = 1'b1; iS_READ_DATA = 32'hDEAD_BEEF;
    #1;
    checkOutput("spurious_dv_blocked", 64'({oM1_READ_DATAVALID, oM0_READ_DATAVALID}), 64'd0);
    waitClk();
    iS_READ_DATAVALID = 1'b0;
    checkOutput("err_set", 64'(oERR), 64'd1);
    waitClk(3);
    checkOutput("err_sticky", 64'(oERR), 64'd1);

    // M1 read, one beat returns, then reset lands in the middle of RDATA.
    applyStimulus(1, 1, 0, 32'h0000_7000, 32'h0, 5'd4);
    waitClk();
    checkOutput("rst_read_grant", 64'(oGRANT), 64'(2'b10));
    waitClk();
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 5'd0);
    iS_READ_DATAVALID = 1'b1; iS_READ_DATA = 32'h1234_5678;
    expReadQ.push_back(readEntry(1, 32'h1234_5678));
    waitClk();
    iS_READ_DATAVALID = 1'b0;
    checkOutput("rst_still_granted", 64'(oGRANT), 64'(2'b10));
    iRESET = 1'b1;
    #1;
    checkResetOutputs("midburst_reset");
    waitClk();
    iRESET = 1'b0;
    waitClk();
    checkOutput("rst_read_queue_drained", 64'(expReadQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
